bus_cmd_ctrl: RTL
=================

BUS_CMD_CTRL -- requirements
Module: bus_cmd_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: wait states inserted on memory and code-fetch cycles (0..7).
REQ-002 SHALL have parameter IO_WAIT, default 1: wait states inserted on I/O and INTA cycles (0..7).
REQ-003 SHALL have port CLK in 1: single bus clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET in 1: asynchronous, active-high reset.
REQ-005 SHALL have port s2_s0_in in 3: CPU bus status; 3'b111 means passive.
REQ-006 SHALL have port rdy_in in 1: external device ready; high means ready.
REQ-007 SHALL have port ale out 1: address latch enable.
REQ-008 SHALL have ports memr_n, memw_n, ior_n, iow_n and inta_n, each out 1: active-low bus commands.
REQ-009 SHALL have port den out 1: data buffer enable, active-high.
REQ-010 SHALL have port dt_r_n out 1: transceiver direction; 1 = transmit, 0 = receive.
REQ-011 SHALL have port ready_out out 1: READY to CPU.
REQ-012 SHALL have port cycle_type out 3: status latched at T1.
REQ-013 SHALL have port halted out 1: high after a halt cycle until the next bus cycle starts.

Function
REQ-014 SHALL decode status as: 000 INTA, 001 IO read, 010 IO write, 011 halt, 100 code fetch, 101 mem read, 110 mem write, 111 passive.
REQ-015 SHALL register s2_s0_in each cycle as prev_status; a cycle start is s2_s0_in != 111 with prev_status == 111.
REQ-016 SHALL use FSM states TI, T1, T2, T3, TW, T4.
REQ-017 SHALL make the following transitions:
- TI→T1 on cycle start.
- T1→T2, except halt: T1→TI.
- T2→T3.
- T3/TW→T4 when wait_cnt==0 and rdy_q==1; otherwise →TW.
- T4→T1 on cycle start; otherwise →TI.
REQ-018 SHALL drive ale high only in T1, and SHALL latch cycle_type in T1.
REQ-019 SHALL assert the decoded command in T2, T3 and TW, and SHALL deassert it in T4.
REQ-020 SHALL keep all commands inactive for halt and passive.
REQ-021 SHALL assert den in T2, T3 and TW for all non-halt cycles.
REQ-022 SHALL set dt_r_n: 0 from T1 through T4 for reads, code fetch and INTA; 1 otherwise.
REQ-023 SHALL load wait_cnt (3 bits) in T2 from MEM_WAIT for 100/101/110 and from IO_WAIT for 000/001/010.
REQ-024 SHALL decrement wait_cnt in each T3/TW while it is nonzero, saturating at 0.
REQ-025 SHALL drive ready_out = 1 except in T3/TW when (wait_cnt!=0 or rdy_q==0).
REQ-026 SHALL ignore status changes between T2 and T4, since cycle_type is latched.
REQ-027 SHALL set halted in the T1 of a halt cycle and SHALL clear it in the T1 of the next cycle.
REQ-028 SHALL stay in TW indefinitely while rdy_q is low; there is no timeout.

Reset
REQ-029 SHALL apply these values on RESET, asynchronously:
- state=TI, prev_status=111, wait_cnt=0, cycle_type=111.
- ale=0, all command outputs=1, den=0, dt_r_n=1, ready_out=1, halted=0.
REQ-030 SHALL, on RESET asserted mid-cycle, drop commands immediately and restart from TI after release.

Configuration
REQ-031 SHALL, with BUS_CMD_READY_SYNC_EN defined, form rdy_q from rdy_in through a two-flop synchronizer reset to 0.
REQ-032 SHALL, without BUS_CMD_READY_SYNC_EN, use rdy_q = rdy_in directly with zero latency.

Structure
REQ-033 SHALL place the state enum, the status code constants (STAT_INTA…STAT_PASSIVE) and the command-decode function in shared package bus_cmd_pkg.
REQ-034 SHALL implement the ready synchronizer as sub-module bus_cmd_ready_sync, instantiated only under BUS_CMD_READY_SYNC_EN.

Verification
REQ-035 SHALL cover: mem read 101 with MEM_WAIT=0, rdy_in=1 → T1,T2,T3,T4; memr_n low for exactly 2 cycles; ready_out never low.
REQ-036 SHALL cover: IO write 010 with IO_WAIT=2 → one T3 plus two TW; iow_n low for 4 cycles; dt_r_n=1; ready_out low for 2 cycles.
REQ-037 SHALL cover: mem read with rdy_in held low 5 cycles after T2 (sync on) → TW persists until rdy_q rises, then T4; memr_n stays low throughout.
REQ-038 SHALL cover: halt 011 → ale pulses 1 cycle; no command or den; halted=1 until the next cycle's T1.
REQ-039 SHALL cover: back-to-back fetch 100 then INTA 000, new status in T4 → T4→T1 directly; inta_n low in the second cycle; no TI gap.
REQ-040 SHALL cover: RESET asserted during TW of an IO read → ior_n=1 and den=0 the same cycle; FSM in TI after release; next status edge starts T1.

Source files
------------

// File: rtl/bus_cmd_pkg.sv
// Shared types, status codes and command decode for the bus command controller.
package bus_cmd_pkg;

  typedef enum logic [2:0] {
    ST_TI = 3'd0,
    ST_T1 = 3'd1,
    ST_T2 = 3'd2,
    ST_T3 = 3'd3,
    ST_TW = 3'd4,
    ST_T4 = 3'd5
  } bus_state_t;

  localparam logic [2:0] STAT_INTA    = 3'b000;
  localparam logic [2:0] STAT_IO_RD   = 3'b001;
  localparam logic [2:0] STAT_IO_WR   = 3'b010;
  localparam logic [2:0] STAT_HALT    = 3'b011;
  localparam logic [2:0] STAT_FETCH   = 3'b100;
  localparam logic [2:0] STAT_MEM_RD  = 3'b101;
  localparam logic [2:0] STAT_MEM_WR  = 3'b110;
  localparam logic [2:0] STAT_PASSIVE = 3'b111;

  // Active-high command enables; the top inverts them onto the pins.
  typedef struct packed {
    logic memr;
    logic memw;
    logic ior;
    logic iow;
    logic inta;
  } bus_cmd_t;

  function automatic bus_cmd_t decode_cmd(input logic [2:0] status);
    bus_cmd_t cmd;
    cmd = '0;
    case (status)
      STAT_INTA:   cmd.inta = 1'b1;
      STAT_IO_RD:  cmd.ior  = 1'b1;
      STAT_IO_WR:  cmd.iow  = 1'b1;
      STAT_FETCH:  cmd.memr = 1'b1;
      STAT_MEM_RD: cmd.memr = 1'b1;
      STAT_MEM_WR: cmd.memw = 1'b1;
      default:     cmd = '0;
    endcase
    return cmd;
  endfunction

  function automatic logic is_receive(input logic [2:0] status);
    return (status == STAT_INTA) || (status == STAT_IO_RD) ||
           (status == STAT_FETCH) || (status == STAT_MEM_RD);
  endfunction

  function automatic logic is_mem(input logic [2:0] status);
    return (status == STAT_FETCH) || (status == STAT_MEM_RD) || (status == STAT_MEM_WR);
  endfunction

endpackage

// File: rtl/bus_cmd_ready_sync.sv
// Two-flop synchronizer for the external ready input; output resets to not-ready.
module bus_cmd_ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_cmd_ctrl.sv
// Bus command controller: decodes CPU status into bus commands with wait states.
// Optional BUS_CMD_READY_SYNC_EN passes rdy_in through a two-flop synchronizer.
module bus_cmd_ctrl
  import bus_cmd_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] s2_s0_in,
  input  logic       rdy_in,
  output logic       ale,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n,
  output logic       inta_n,
  output logic       den,
  output logic       dt_r_n,
  output logic       ready_out,
  output logic [2:0] cycle_type,
  output logic       halted
);

  localparam logic [2:0] MEM_WAIT_L = 3'(MEM_WAIT);
  localparam logic [2:0] IO_WAIT_L  = 3'(IO_WAIT);

  bus_state_t state, state_nxt;
  logic [2:0] prev_status;
  logic [2:0] wait_cnt;
  logic       rdy_q;
  logic       cycle_start;
  logic       in_wait;
  bus_cmd_t   cmd;

`ifdef BUS_CMD_READY_SYNC_EN
  bus_cmd_ready_sync u_ready_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (rdy_in),
    .q   (rdy_q)
  );
`else
  assign rdy_q = rdy_in;
`endif

  assign cycle_start = (s2_s0_in != STAT_PASSIVE) && (prev_status == STAT_PASSIVE);
  assign in_wait     = (state == ST_T3) || (state == ST_TW);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_TI;
      prev_status <= STAT_PASSIVE;
      wait_cnt    <= 3'd0;
      cycle_type  <= STAT_PASSIVE;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_status <= s2_s0_in;
      // Status is captured on entry so it is already valid throughout T1.
      if (state_nxt == ST_T1) begin
        cycle_type <= s2_s0_in;
        halted     <= (s2_s0_in == STAT_HALT);
      end
      if (state == ST_T2)
        wait_cnt <= is_mem(cycle_type) ? MEM_WAIT_L : IO_WAIT_L;
      else if (in_wait && (wait_cnt != 3'd0))
        wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ale       = 1'b0;
    den       = 1'b0;
    dt_r_n    = 1'b1;
    ready_out = 1'b1;
    cmd       = '0;

    case (state)
      ST_TI: if (cycle_start) state_nxt = ST_T1;
      ST_T1: state_nxt = (cycle_type == STAT_HALT) ? ST_TI : ST_T2;
      ST_T2: state_nxt = ST_T3;
      ST_T3,
      ST_TW: state_nxt = ((wait_cnt == 3'd0) && rdy_q) ? ST_T4 : ST_TW;
      ST_T4: state_nxt = cycle_start ? ST_T1 : ST_TI;
      default: state_nxt = ST_TI;
    endcase

    if (state == ST_T1) ale = 1'b1;

    if ((state == ST_T2) || in_wait) begin
      cmd = decode_cmd(cycle_type);
      den = (cycle_type != STAT_HALT) && (cycle_type != STAT_PASSIVE);
    end

    if ((state != ST_TI) && is_receive(cycle_type)) dt_r_n = 1'b0;

    if (in_wait && ((wait_cnt != 3'd0) || !rdy_q)) ready_out = 1'b0;
  end

  assign memr_n = ~cmd.memr;
  assign memw_n = ~cmd.memw;
  assign ior_n  = ~cmd.ior;
  assign iow_n  = ~cmd.iow;
  assign inta_n = ~cmd.inta;

endmodule
